// File: rtl/bios_loader_pkg.sv
// rtl/bios_loader_pkg.sv - shared constants and reader FSM state encoding for bios_loader
package bios_loader_pkg;

    localparam int BLK_WORDS = 64;
    localparam int BANK_AW   = 6;
    localparam int BIOS_AW   = 13;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RELEASE,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/bios_loader_if.sv
// rtl/bios_loader_if.sv - data_io download bus plus system BIOS port, loader side is master
interface bios_loader_if;
    import bios_loader_pkg::*;

    logic               ioctl_download;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic               bios_req;
    logic               bios_wr;
    logic [BIOS_AW-1:0] bios_addr;
    logic [15:0]        bios_din;
    logic               bios_loaded;
    logic               overflow;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        output bios_wr, bios_addr, bios_din, bios_loaded, overflow
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
        input  bios_wr, bios_addr, bios_din, bios_loaded, overflow
    );

endinterface

// File: rtl/bios_loader_ram.sv
// rtl/bios_loader_ram.sv - two-bank word buffer, one write port and one registered read port
module bios_loader_ram
    import bios_loader_pkg::*;
#(
    parameter int AW = BANK_AW
) (
    input  logic        clk_sdr,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [AW:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_en,
    input  logic [AW:0] rd_addr,
    output logic [15:0] rd_data
);

    logic [15:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk_sdr) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the bios_din holding register, so it only
    // advances on an enabled read and clears on reset.
    always_ff @(posedge clk_sdr) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bios_loader.sv
// rtl/bios_loader.sv - BIOS image byte packer, ping-pong block buffer and system BIOS port driver
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int          BLK_WORDS = 64,
    parameter logic [15:0] PAD_WORD  = 16'hFFFF
) (
    input  logic          clk_sdr,
    input  logic          reset_n,
    bios_loader_if.master bus
);

    localparam int AW = $clog2(BLK_WORDS);

    state_t             state, state_nxt;

    logic               dl_q, dl_rise, dl_fall;
    logic               host_wr, host_even, host_odd;
    logic [AW:0]        io_pos;
    logic [1:0]         bank_valid;
    logic [7:0]         low_byte;
    logic               low_pend;
    logic [AW:0]        low_pos;
    logic [AW:0]        fill_pos;
    logic               flush_pend, drain_pend;
    logic               rd_bank;
    logic [AW-1:0]      rd_ptr;
    logic [BIOS_AW-1:0] bios_addr_q;
    logic               loaded_q, overflow_q;

    logic               rd_en, blk_done;
    logic               fl_step, fl_low, fl_wr, fl_done, set_loaded;
    logic [AW:0]        fl_pos;
    logic [15:0]        fl_data;

    logic               ram_we;
    logic [AW:0]        ram_wpos;
    logic [15:0]        ram_wdata, ram_rdata;
    logic               unused_addr;

    assign dl_rise   = bus.ioctl_download & ~dl_q;
    assign dl_fall   = ~bus.ioctl_download & dl_q;
    assign host_wr   = bus.ioctl_wr & bus.ioctl_download & ~dl_rise;
    assign host_even = host_wr & ~bus.ioctl_addr[0];
    assign host_odd  = host_wr & bus.ioctl_addr[0];
    // {bank, word} position of the addressed byte pair
    assign io_pos    = bus.ioctl_addr[AW+1:1];
    assign unused_addr = ^bus.ioctl_addr[24:AW+2];

    // Flush writes only happen with the download low, so they never collide
    // with host writes.
    assign ram_we    = (host_odd & ~bank_valid[io_pos[AW]]) | fl_wr;
    assign ram_wpos  = fl_wr ? fl_pos : io_pos;
    assign ram_wdata = fl_wr ? fl_data : {bus.ioctl_dout, low_byte};

    bios_loader_ram #(.AW(AW)) u_ram (
        .clk_sdr (clk_sdr),
        .reset_n (reset_n),
        .wr_en   (ram_we),
        .wr_addr (ram_wpos),
        .wr_data (ram_wdata),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_ptr}),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk_sdr) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        blk_done   = 1'b0;
        fl_step    = 1'b0;
        fl_low     = 1'b0;
        fl_wr      = 1'b0;
        fl_done    = 1'b0;
        set_loaded = 1'b0;
        fl_pos     = fill_pos;
        fl_data    = PAD_WORD;
        if (dl_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bank_valid[rd_bank]) begin
                        state_nxt = SERVE;
                    end else if (flush_pend) begin
                        state_nxt = FLUSH;
                    end else if (drain_pend) begin
                        state_nxt = DRAIN;
                    end
                end
                SERVE: begin
                    if (bus.bios_req) begin
                        rd_en = 1'b1;
                        if (rd_ptr == '1) begin
                            blk_done  = 1'b1;
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!bus.bios_req) begin
                        state_nxt = IDLE;
                    end
                end
                FLUSH: begin
                    // Dangling low byte first, then pad the partial bank up to its last word.
                    if (low_pend) begin
                        fl_step = 1'b1;
                        fl_low  = 1'b1;
                        fl_pos  = low_pos;
                        fl_data = {8'hFF, low_byte};
                        fl_wr   = ~bank_valid[low_pos[AW]];
                    end else if ((fill_pos[AW-1:0] != '0) && !bank_valid[fill_pos[AW]]) begin
                        fl_step = 1'b1;
                        fl_wr   = 1'b1;
                    end else begin
                        fl_done   = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    set_loaded = (bank_valid == 2'b00);
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sdr) begin
        if (!reset_n) begin
            dl_q        <= 1'b0;
            bank_valid  <= 2'b00;
            low_byte    <= 8'h00;
            low_pend    <= 1'b0;
            low_pos     <= '0;
            fill_pos    <= '0;
            flush_pend  <= 1'b0;
            drain_pend  <= 1'b0;
            rd_bank     <= 1'b0;
            rd_ptr      <= '0;
            bios_addr_q <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dl_q <= bus.ioctl_download;
            if (dl_rise) begin
                bank_valid  <= 2'b00;
                low_pend    <= 1'b0;
                fill_pos    <= '0;
                flush_pend  <= 1'b0;
                drain_pend  <= 1'b0;
                rd_bank     <= 1'b0;
                rd_ptr      <= '0;
                bios_addr_q <= '0;
                loaded_q    <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (dl_fall) begin
                    flush_pend <= 1'b1;
                end
                if (host_even) begin
                    low_byte <= bus.ioctl_dout;
                    low_pend <= 1'b1;
                    low_pos  <= io_pos;
                end
                if (host_odd) begin
                    low_pend <= 1'b0;
                    fill_pos <= io_pos + 1'b1;
                    if (bank_valid[io_pos[AW]]) begin
                        overflow_q <= 1'b1;
                    end
                end
                if (fl_step) begin
                    fill_pos <= fl_pos + 1'b1;
                end
                if (fl_low) begin
                    low_pend <= 1'b0;
                    if (!fl_wr) begin
                        overflow_q <= 1'b1;
                    end
                end
                if (fl_done) begin
                    flush_pend <= 1'b0;
                    drain_pend <= 1'b1;
                end
                if (set_loaded) begin
                    loaded_q   <= 1'b1;
                    drain_pend <= 1'b0;
                end
                if (rd_en) begin
                    rd_ptr      <= rd_ptr + 1'b1;
                    bios_addr_q <= bios_addr_q + 1'b1;
                end
                // Reader releases one bank while the writer may complete the other.
                if (blk_done) begin
                    bank_valid[rd_bank] <= 1'b0;
                    rd_bank             <= ~rd_bank;
                end
                if (ram_we && (ram_wpos[AW-1:0] == '1)) begin
                    bank_valid[ram_wpos[AW]] <= 1'b1;
                end
            end
        end
    end

    assign bus.bios_wr     = (state == SERVE) || (state == RELEASE);
    assign bus.bios_addr   = bios_addr_q;
    assign bus.bios_din    = ram_rdata;
    assign bus.bios_loaded = loaded_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_bios_loader.sv
// tb/tb_bios_loader.sv - directed self-checking bench for bios_loader
module tb_bios_loader;

    logic clk_sdr;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    bios_loader_if bus();

    bios_loader #(
        .BLK_WORDS (64),
        .PAD_WORD  (16'hFFFF)
    ) dut (
        .clk_sdr (clk_sdr),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_sdr = 1'b0;
    always #5 clk_sdr = ~clk_sdr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int k, input logic [7:0] xr);
        logic [31:0] kk;
        kk = k;
        return kk[7:0] ^ {kk[9:8], 6'b0} ^ xr;
    endfunction

    function automatic logic [15:0] exp_word(input int w, input int nb, input logic [7:0] xr);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = (2*w < nb) ? byte_of(2*w, xr) : 8'hFF;
        hi = (2*w+1 < nb) ? byte_of(2*w+1, xr) : 8'hFF;
        return {hi, lo};
    endfunction

    task automatic start_dl();
        @(negedge clk_sdr);
        bus.ioctl_download = 1'b1;
    endtask

    task automatic end_dl();
        @(negedge clk_sdr);
        bus.ioctl_download = 1'b0;
    endtask

    task automatic send_bytes(input int nb, input logic [7:0] xr);
        for (int k = 0; k < nb; k++) begin
            @(negedge clk_sdr);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(k);
            bus.ioctl_dout = byte_of(k, xr);
        end
        @(negedge clk_sdr);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic read_block(input int blk, input int nb, input logic [7:0] xr);
        int n;
        n = 0;
        while (!bus.bios_wr && n < 2000) begin
            @(negedge clk_sdr);
            n++;
        end
        check("bios_wr_pending", 32'(bus.bios_wr), 32'd1);
        for (int j = 0; j < 64; j++) begin
            bus.bios_req = 1'b1;
            @(negedge clk_sdr);
            check("bios_din", 32'(bus.bios_din), 32'(exp_word(blk*64 + j, nb, xr)));
            check("bios_addr", 32'(bus.bios_addr), 32'((blk*64 + j + 1) % 8192));
        end
        bus.bios_req = 1'b0;
        @(negedge clk_sdr);
        check("bios_wr_fall", 32'(bus.bios_wr), 32'd0);
    endtask

    task automatic wait_loaded();
        int n;
        n = 0;
        while (!bus.bios_loaded && n < 500) begin
            @(negedge clk_sdr);
            n++;
        end
        check("bios_loaded", 32'(bus.bios_loaded), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.bios_req       = 1'b0;
        repeat (3) @(negedge clk_sdr);
        reset_n = 1'b1;
        @(negedge clk_sdr);

        // reset state
        check("rst_bios_wr", 32'(bus.bios_wr), 32'd0);
        check("rst_bios_addr", 32'(bus.bios_addr), 32'd0);
        check("rst_bios_din", 32'(bus.bios_din), 32'd0);
        check("rst_loaded", 32'(bus.bios_loaded), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        // single block, with fill-to-bios_wr latency
        start_dl();
        send_bytes(128, 8'h00);
        check("fill_lat_0", 32'(bus.bios_wr), 32'd0);
        @(negedge clk_sdr);
        check("fill_lat_1", 32'(bus.bios_wr), 32'd1);
        end_dl();
        read_block(0, 128, 8'h00);
        wait_loaded();
        check("single_overflow", 32'(bus.overflow), 32'd0);

        // ping-pong, consumer stalled until both banks full
        start_dl();
        send_bytes(256, 8'h00);
        end_dl();
        check("pp_overflow_pre", 32'(bus.overflow), 32'd0);
        read_block(0, 256, 8'h00);
        read_block(1, 256, 8'h00);
        wait_loaded();
        check("pp_overflow", 32'(bus.overflow), 32'd0);

        // overflow: third block dropped, first two intact
        start_dl();
        send_bytes(384, 8'h00);
        end_dl();
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        read_block(0, 384, 8'h00);
        read_block(1, 384, 8'h00);
        wait_loaded();
        check("ovf_no_third", 32'(bus.bios_wr), 32'd0);
        check("ovf_addr_end", 32'(bus.bios_addr), 32'd128);

        // odd tail: 131 bytes, padded second block
        start_dl();
        send_bytes(131, 8'h00);
        end_dl();
        read_block(0, 131, 8'h00);
        read_block(1, 131, 8'h00);
        wait_loaded();
        check("tail_overflow", 32'(bus.overflow), 32'd0);

        // abort mid-SERVE with a one-cycle reset
        start_dl();
        send_bytes(128, 8'h00);
        end_dl();
        for (int j = 0; j < 10; j++) begin
            bus.bios_req = 1'b1;
            @(negedge clk_sdr);
        end
        check("abort_mid_addr", 32'(bus.bios_addr), 32'd10);
        bus.bios_req = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk_sdr);
        reset_n = 1'b1;
        check("abort_bios_wr", 32'(bus.bios_wr), 32'd0);
        check("abort_bios_addr", 32'(bus.bios_addr), 32'd0);
        check("abort_bios_din", 32'(bus.bios_din), 32'd0);
        check("abort_loaded", 32'(bus.bios_loaded), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        repeat (5) @(negedge clk_sdr);
        check("abort_quiet", 32'(bus.bios_wr), 32'd0);
        start_dl();
        send_bytes(128, 8'h3C);
        end_dl();
        read_block(0, 128, 8'h3C);
        wait_loaded();

        // restart after bios_loaded
        start_dl();
        @(negedge clk_sdr);
        check("restart_clear", 32'(bus.bios_loaded), 32'd0);
        send_bytes(128, 8'hA5);
        end_dl();
        read_block(0, 128, 8'hA5);
        wait_loaded();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
